data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_array.sv | 49 ++++
 rtl/data_mem_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Package    : dmem_pkg                                                      |
// | Purpose    : Shared access-size encodings, controller FSM state encoding   |
// |              and the load-extension helper for data_mem_ctrl.              |
// | Revision   : 1.0 - initial release                                         |
// +---------------------------------------------------------------------------+
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 also decodes as word

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Select the addressed byte/half from a storage word and extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = {{24{sgn & b[7]}}, b};
         SZ_HALF: r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module     : dmem_array                                                    |
// | Purpose    : 2**ADDR_W x 32-bit storage with a synchronous byte-enable     |
// |              write port and a synchronous (registered) read port.          |
// |              Contents are never reset.                                     |
// | Ports      : clk        - clock, rising edge                               |
// |              wr_en_i    - write strobe                                     |
// |              wr_be_i    - per-byte write enables                           |
// |              wr_addr_i  - write word index                                 |
// |              wr_data_i  - write data (lanes already positioned)            |
// |              rd_en_i    - read strobe, updates rd_data_o                   |
// |              rd_addr_i  - read word index                                  |
// |              rd_data_o  - last word read, held until the next read         |
// | Revision   : 1.0 - initial release                                         |
// +---------------------------------------------------------------------------+
module dmem_array #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [3:0]        wr_be_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [31:0]       wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [31:0]       rd_data_o
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be_i[i]) begin
               mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
         end
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module     : data_mem_ctrl                                                 |
// | Purpose    : Single-outstanding data-memory controller. Accepts one        |
// |              byte/half/word load or store in IDLE, waits WAIT_CYCLES,      |
// |              then commits/reads storage and pulses resp_valid.             |
// | Macro      : DMEM_MISALIGN_ERR_EN - flag misaligned half/word accesses     |
// |              with resp_err, suppressing the store and zeroing rdata.       |
// | Ports      : clk, rst_n (async, active-low)                                |
// |              req_valid/req_ready handshake; req_we, req_addr (byte),       |
// |              req_size, req_signed, req_wdata (right-aligned)               |
// |              resp_valid (1-cycle pulse), resp_rdata, resp_err              |
// | Revision   : 1.0 - initial release                                         |
// +---------------------------------------------------------------------------+
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               enter_resp;

   // Captured request
   logic               we_q;
   logic [ADDR_W+1:0]  addr_q;
   logic [1:0]         size_q;
   logic               signed_q;
   logic [31:0]        wdata_q;

   // Response context, frozen on entry to RESP so rdata holds until the next one
   logic               rsp_zero_q;
   logic               rsp_err_q;
   logic [1:0]         rsp_size_q;
   logic [1:0]         rsp_off_q;
   logic               rsp_signed_q;

   // With zero wait the access happens on the accept edge itself, so the live
   // request fields are used; otherwise the captured copy is used.
   logic               acc_we;
   logic [ADDR_W+1:0]  acc_addr;
   logic [1:0]         acc_size;
   logic               acc_signed;
   logic [31:0]        acc_wdata;
   logic               misalign;
   logic [3:0]         wr_be;
   logic [31:0]        wr_data;
   logic [31:0]        rd_data;
   logic               unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   always_comb begin
      if (state_q == ST_IDLE) begin
         acc_we     = req_we;
         acc_addr   = req_addr[ADDR_W+1:0];
         acc_size   = req_size;
         acc_signed = req_signed;
         acc_wdata  = req_wdata;
      end else begin
         acc_we     = we_q;
         acc_addr   = addr_q;
         acc_size   = size_q;
         acc_signed = signed_q;
         acc_wdata  = wdata_q;
      end
   end

`ifdef DMEM_MISALIGN_ERR_EN
   assign misalign = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                     (acc_size[1] && (acc_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = rst_n;
            if (req_valid && rst_n) begin
               if (WAIT_CYCLES == 0) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- Request capture ----------------
   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         we_q     <= req_we;
         addr_q   <= req_addr[ADDR_W+1:0];
         size_q   <= req_size;
         signed_q <= req_signed;
         wdata_q  <= req_wdata;
      end
   end

   // ---------------- Store lane steering ----------------
   always_comb begin
      wr_be   = 4'b1111;
      wr_data = acc_wdata;
      case (acc_size)
         SZ_BYTE: begin
            wr_be   = 4'b0001 << acc_addr[1:0];
            wr_data = {4{acc_wdata[7:0]}};
         end
         SZ_HALF: begin
            wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{acc_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk       (clk),
      .wr_en_i   (enter_resp && acc_we && !misalign),
      .wr_be_i   (wr_be),
      .wr_addr_i (acc_addr[ADDR_W+1:2]),
      .wr_data_i (wr_data),
      .rd_en_i   (enter_resp && !acc_we),
      .rd_addr_i (acc_addr[ADDR_W+1:2]),
      .rd_data_o (rd_data)
   );

   // ---------------- Response ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_zero_q   <= 1'b1;
         rsp_err_q    <= 1'b0;
         rsp_size_q   <= SZ_BYTE;
         rsp_off_q    <= 2'b00;
         rsp_signed_q <= 1'b0;
      end else if (enter_resp) begin
         rsp_zero_q   <= acc_we | misalign;
         rsp_err_q    <= misalign;
         rsp_size_q   <= acc_size;
         rsp_off_q    <= acc_addr[1:0];
         rsp_signed_q <= acc_signed;
      end
   end

   assign resp_rdata = rsp_zero_q ? 32'd0
                                  : load_extend(rd_data, rsp_size_q, rsp_off_q, rsp_signed_q);
   assign resp_err   = rsp_err_q;

endmodule
`default_nettype wire
